inst_fetch_mem: RTL and testbench
=================================

INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Interface
REQ-001 SHALL have parameter XLEN, default 64, PC/address width.
REQ-002 SHALL have parameter DEPTH, default 256, instruction words stored (power of two, 32 to 4096).
REQ-003 SHALL have parameter BASE_ADDR, default 0, byte address of word 0.
REQ-004 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports fetch_req (in, 1, fetch request) and fetch_pc (in, XLEN, byte PC).
REQ-007 SHALL have port fetch_stall, input, 1; when high, the request is not accepted and outputs hold.
REQ-008 SHALL have outputs fetch_valid (1), fetch_inst (32), fetch_fault (1) and fetch_cause (2: 00 none, 01 access, 10 misaligned, 11 parity).
REQ-009 SHALL have load-port ports ld_valid (in, 1), ld_ready (out, 1), ld_addr (in, log2(DEPTH)), ld_data (in, 32) and ld_last (in, 1).
REQ-010 SHALL have ports run_start (in, 1, start pulse), halt (in, 1, return to idle) and busy (out, 1, high in LOAD).

Function
REQ-011 SHALL implement an FSM with states IDLE, LOAD and RUN.
- IDLE: ld_valid -> LOAD; run_start -> RUN.
- LOAD: accepted beat with ld_last -> RUN; run_start -> RUN.
- RUN: halt -> IDLE.
REQ-012 SHALL drive ld_ready=1 in IDLE and LOAD and 0 in RUN; a beat is accepted when ld_valid&&ld_ready and writes ld_data to word ld_addr in that cycle.
REQ-013 SHALL accept a fetch only in RUN when fetch_req=1 and fetch_stall=0, and ignore fetch_req in IDLE and LOAD.
REQ-014 SHALL assert fetch_valid and present fetch_inst and fetch_fault/fetch_cause exactly one cycle after acceptance (latency 1).
REQ-015 SHALL drop fetch_valid to 0 the cycle after a non-accepted fetch_req when fetch_stall=0.
REQ-016 SHALL hold fetch_valid, fetch_inst, fetch_fault and fetch_cause unchanged while fetch_stall=1.
REQ-017 SHALL use word index (fetch_pc-BASE_ADDR)>>2, computed at XLEN width with no truncation before the range check.
REQ-018 SHALL check faults in priority order:
- misaligned when fetch_pc[1:0]!=0;
- access when fetch_pc<BASE_ADDR or fetch_pc>=BASE_ADDR+4*DEPTH;
- parity per REQ-029.
REQ-019 SHALL, on a fault, return fetch_inst=32'h0000_0013 (NOP) with fetch_fault=1, and SHALL NOT read the array.
REQ-020 SHALL treat the last word (BASE_ADDR+4*DEPTH-4) as valid and the next word address as an access fault.
REQ-021 SHALL, when halt and run_start are high in the same cycle, give halt priority.
REQ-022 SHALL, on RUN->IDLE via halt, deassert fetch_valid in the next cycle.
REQ-023 SHALL drive busy=1 exactly while in LOAD.

Reset
REQ-024 SHALL, while rstn=0, immediately force state=IDLE, fetch_valid=0, fetch_inst=0, fetch_fault=0, fetch_cause=00 and busy=0.
REQ-025 SHALL leave memory contents unaffected by reset.
REQ-026 SHALL abandon an in-progress LOAD on reset mid-operation, keeping already-written words intact.

Configuration
REQ-027 SHALL use the macro IMEM_PARITY_EN to compile in the parity feature.
REQ-028 SHALL, when IMEM_PARITY_EN is defined, store an even-parity bit per word on each write.
REQ-029 SHALL, when IMEM_PARITY_EN is defined, raise a parity fault with cause 11 and fetch_inst=NOP on a read mismatch.
REQ-030 SHALL, when IMEM_PARITY_EN is undefined, remove the parity storage, never produce cause 11, and leave all else identical.

Structure
REQ-031 SHALL define the cause codes, the FSM state enum and the NOP constant in shared package imem_pkg.
REQ-032 SHALL contain one sub-module, imem_ram: single-port synchronous RAM of DEPTH x (32 or 33 bits), write-first disabled (read returns old data).

Verification
REQ-033 SHALL verify load then run: load words 0..3 = 0x11,0x22,0x33,0x44 with ld_last on word 3 -> state RUN; fetch_pc=0x8 -> next cycle fetch_valid=1, fetch_inst=0x33.
REQ-034 SHALL verify stall: accept fetch_pc=0x4, then stall 3 cycles with fetch_pc=0xC -> fetch_inst stays 0x22 for 3 cycles, becomes 0x44 one cycle after stall release.
REQ-035 SHALL verify boundaries (DEPTH=256, BASE_ADDR=0x1000):
- fetch_pc=0x13FC -> valid word;
- 0x1400 -> cause 01, inst 0x13;
- 0xFFC -> cause 01;
- 0x1002 -> cause 10.
REQ-036 SHALL verify reset mid-load: assert rstn=0 after 2 of 4 beats -> state IDLE, fetch_valid=0; words 0,1 are readable after run_start.
REQ-037 SHALL verify halt/run_start collision: assert both in RUN -> IDLE, ld_ready=1 next cycle, fetch_req ignored.
REQ-038 SHALL verify parity (IMEM_PARITY_EN defined): force-flip a stored bit of word 5, fetch 0x14 -> fetch_fault=1, cause 11, fetch_inst=0x13.

Source files
------------

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction fetch memory:
//   state_e  - control FSM states (IDLE / LOAD / RUN)
//   cause_e  - fetch fault cause codes presented on fetch_cause
//   NOP_INST - instruction returned in place of data on any fault
//   even_parity - parity bit that gives an even number of ones across
//                 {parity, data}
// ---------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_ACCESS   = 2'b01,
        CAUSE_MISALIGN = 2'b10,
        CAUSE_PARITY   = 2'b11
    } cause_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// ---------------------------------------------------------------------------
// imem_ram
// Single-port synchronous RAM, DEPTH x WIDTH. One access per cycle: when en
// is high the word at addr is read into rdata and, if we is also high,
// wdata is written. A read that coincides with a write returns the old
// contents. rdata holds its value in cycles with en low.
//
// Ports:
//   clk   in   clock, rising edge
//   en    in   access enable
//   we    in   write enable (qualified by en)
//   addr  in   word address, $clog2(DEPTH) bits
//   wdata in   write data, WIDTH bits
//   rdata out  registered read data, WIDTH bits
// ---------------------------------------------------------------------------
module imem_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and its read register have no reset so the storage
    // maps onto plain RAM macros and contents survive a reset.
    always_ff @(posedge clk) begin
        if (en) begin
            // NOTE: non-blocking assignments here make the read see the
            // pre-write word, which is exactly the read-old-data behaviour.
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/inst_fetch_mem.sv
// ---------------------------------------------------------------------------
// inst_fetch_mem
// Loadable instruction memory with a one-cycle fetch port.
//
// A control FSM sequences the block: IDLE accepts load beats or a run start,
// LOAD streams words into the array, RUN serves instruction fetches. Each
// accepted fetch returns its word (or a NOP plus fault indication) one cycle
// later. Address faults are decided before the array access so a faulting
// fetch never reads the RAM.
//
// Build option:
//   IMEM_PARITY_EN - when defined, each word carries an even-parity bit and a
//                    read mismatch is reported as cause 11 with a NOP.
//
// Parameters:
//   XLEN      PC/address width
//   DEPTH     instruction words (power of two, 32..4096)
//   BASE_ADDR byte address of word 0
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   fetch_req, fetch_pc             fetch request and byte PC
//   fetch_stall                     blocks acceptance and freezes fetch outputs
//   fetch_valid, fetch_inst         fetch response (latency 1)
//   fetch_fault, fetch_cause        fault flag and cause (00/01/10/11)
//   ld_valid, ld_ready              load handshake (ready in IDLE and LOAD)
//   ld_addr, ld_data, ld_last       load beat word address, data, last flag
//   run_start, halt                 enter RUN / return to IDLE (halt wins)
//   busy                            high while in LOAD
// ---------------------------------------------------------------------------
module inst_fetch_mem
    import imem_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter int              DEPTH     = 256,
    parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     fetch_req,
    input  logic [XLEN-1:0]          fetch_pc,
    input  logic                     fetch_stall,
    output logic                     fetch_valid,
    output logic [31:0]              fetch_inst,
    output logic                     fetch_fault,
    output logic [1:0]               fetch_cause,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data,
    input  logic                     ld_last,
    input  logic                     run_start,
    input  logic                     halt,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);

`ifdef IMEM_PARITY_EN
    localparam int RAM_W = 33;
`else
    localparam int RAM_W = 32;
`endif

    // One past the last valid byte address, one bit wider than XLEN so a
    // window that ends at the top of the address space does not wrap.
    localparam logic [XLEN:0] LIMIT = {1'b0, BASE_ADDR} + ((XLEN+1)'(DEPTH) << 2);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaulting state_d before the case keeps every path assigned,
        // so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (ld_valid) begin
                    state_d = S_LOAD;
                end else if (run_start) begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                if ((ld_valid && ld_last) || run_start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // run_start has no effect in RUN, so halt always wins.
                if (halt) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic in_run;
    logic ld_accept;

    assign in_run    = (state_q == S_RUN);
    assign ld_ready  = !in_run;
    assign busy      = (state_q == S_LOAD);
    assign ld_accept = ld_valid && ld_ready;

    // ------------------------------------------------------------------
    // Fetch decode
    // ------------------------------------------------------------------
    logic            fetch_accept;
    logic            misaligned;
    logic            out_of_range;
    logic            addr_fault;
    logic [XLEN-1:0] pc_offset;
    logic [AW-1:0]   word_idx;
    cause_e          addr_cause;

    // A halt in the same cycle suppresses the fetch so valid drops right
    // after the return to IDLE.
    assign fetch_accept = in_run && !halt && fetch_req && !fetch_stall;

    assign misaligned   = (fetch_pc[1:0] != 2'b00);
    assign out_of_range = (fetch_pc < BASE_ADDR) || ({1'b0, fetch_pc} >= LIMIT);
    assign addr_fault   = misaligned || out_of_range;
    assign addr_cause   = misaligned   ? CAUSE_MISALIGN :
                          out_of_range ? CAUSE_ACCESS   : CAUSE_NONE;

    // Offset is formed at full width; only in-range PCs ever use the index.
    assign pc_offset = fetch_pc - BASE_ADDR;
    assign word_idx  = AW'(pc_offset >> 2);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic             ram_en;
    logic [AW-1:0]    ram_addr;
    logic [RAM_W-1:0] ram_wdata;
    logic [RAM_W-1:0] ram_rdata;
    logic             rd_en;

    assign rd_en    = fetch_accept && !addr_fault;
    // Loads only happen outside RUN and reads only inside it, so the single
    // port never sees both in one cycle.
    assign ram_en   = ld_accept || rd_en;
    assign ram_addr = ld_accept ? ld_addr : word_idx;

`ifdef IMEM_PARITY_EN
    assign ram_wdata = {even_parity(ld_data), ld_data};
`else
    assign ram_wdata = ld_data;
`endif

    imem_ram #(
        .DEPTH (DEPTH),
        .WIDTH (RAM_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ld_accept),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    logic   valid_q;
    logic   fault_q;
    logic   from_ram_q;  // response data comes from the RAM read register
    cause_e cause_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            from_ram_q <= 1'b0;
            cause_q    <= CAUSE_NONE;
        end else if (!in_run || halt) begin
            valid_q <= 1'b0;
        end else if (!fetch_stall) begin
            valid_q <= fetch_req;
            if (fetch_req) begin
                fault_q    <= addr_fault;
                from_ram_q <= !addr_fault;
                cause_q    <= addr_cause;
            end
        end
    end

    // The RAM read register only updates on a read, so it holds through a
    // stall together with the flags above.
    logic parity_err;

`ifdef IMEM_PARITY_EN
    assign parity_err = from_ram_q && (^ram_rdata);
`else
    assign parity_err = 1'b0;
`endif

    assign fetch_valid = valid_q;
    assign fetch_fault = fault_q || parity_err;
    assign fetch_cause = parity_err ? CAUSE_PARITY : cause_q;
    assign fetch_inst  = (fault_q || parity_err) ? NOP_INST :
                         from_ram_q              ? ram_rdata[31:0] : 32'h0;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_mem
// Directed bench for inst_fetch_mem (XLEN=64, DEPTH=256, BASE_ADDR=0x1000).
// Stimulus pushes the expected fetch response into a queue; an independent
// monitor pops and compares on every cycle the DUT shows fetch_valid.
// ---------------------------------------------------------------------------
module tb_inst_fetch_mem;

    localparam int              XLEN  = 64;
    localparam int              DEPTH = 256;
    localparam logic [XLEN-1:0] BASE  = 64'h1000;

    logic            clk;
    logic            rstn;
    logic            fetch_req;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_stall;
    logic            fetch_valid;
    logic [31:0]     fetch_inst;
    logic            fetch_fault;
    logic [1:0]      fetch_cause;
    logic            ld_valid;
    logic            ld_ready;
    logic [7:0]      ld_addr;
    logic [31:0]     ld_data;
    logic            ld_last;
    logic            run_start;
    logic            halt;
    logic            busy;

    inst_fetch_mem #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_stall (fetch_stall),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst),
        .fetch_fault (fetch_fault),
        .fetch_cause (fetch_cause),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .run_start   (run_start),
        .halt        (halt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        fault;
        logic [1:0]  cause;
    } exp_t;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            fault;
        logic [1:0]      cause;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid response must match the oldest expectation.
    always @(negedge clk) begin
        if (rstn && fetch_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: got inst %0h with no expected response", fetch_inst);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_inst",  64'(fetch_inst),  64'(mon_e.inst));
                check("resp_fault", 64'(fetch_fault), 64'(mon_e.fault));
                check("resp_cause", 64'(fetch_cause), 64'(mon_e.cause));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic fault, input logic [1:0] cause);
        exp_t e;
        e.inst  = inst;
        e.fault = fault;
        e.cause = cause;
        exp_q.push_back(e);
    endtask

    task automatic beat(input logic [7:0] addr, input logic [31:0] data, input logic last);
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = data;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Issue one accepted fetch; fetch_req is left high for back-to-back use.
    task automatic fetch1(input logic [XLEN-1:0] pc, input logic [31:0] inst,
                          input logic fault, input logic [1:0] cause);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        push(inst, fault, cause);
        tick();
    endtask

    vec_t bvec [7];

    initial begin
        bvec[0] = '{64'h13FC,              32'hDEAD_BEEF, 1'b0, 2'b00};
        bvec[1] = '{64'h1400,              32'h0000_0013, 1'b1, 2'b01};
        bvec[2] = '{64'h0FFC,              32'h0000_0013, 1'b1, 2'b01};
        bvec[3] = '{64'h1002,              32'h0000_0013, 1'b1, 2'b10};
        bvec[4] = '{64'h1401,              32'h0000_0013, 1'b1, 2'b10};
        bvec[5] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013, 1'b1, 2'b01};
        bvec[6] = '{64'h0008,              32'h0000_0013, 1'b1, 2'b01};
    end

    // Watchdog: the directed sequence is fixed-length; this only guards a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn        = 1'b0;
        fetch_req   = 1'b0;
        fetch_pc    = '0;
        fetch_stall = 1'b0;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        ld_last     = 1'b0;
        run_start   = 1'b0;
        halt        = 1'b0;

        // Reset state
        #2;
        check("rst_valid",    64'(fetch_valid), 64'd0);
        check("rst_inst",     64'(fetch_inst),  64'd0);
        check("rst_fault",    64'(fetch_fault), 64'd0);
        check("rst_cause",    64'(fetch_cause), 64'd0);
        check("rst_busy",     64'(busy),        64'd0);
        check("rst_ld_ready", 64'(ld_ready),    64'd1);
        tick();
        tick();
        rstn = 1'b1;

        // Fetches are ignored in IDLE
        fetch_req = 1'b1;
        fetch_pc  = BASE;
        tick();
        check("idle_fetch_ignored", 64'(fetch_valid), 64'd0);
        fetch_req = 1'b0;

        // Load: extra words 5 and 255, then 0..3 with ld_last on word 3
        beat(8'd5, 32'h0000_0055, 1'b0);
        check("load_busy", 64'(busy), 64'd1);
        beat(8'd255, 32'hDEAD_BEEF, 1'b0);
        beat(8'd0, 32'h11, 1'b0);
        beat(8'd1, 32'h22, 1'b0);
        beat(8'd2, 32'h33, 1'b0);
        beat(8'd3, 32'h44, 1'b1);
        check("run_ld_ready", 64'(ld_ready), 64'd0);
        check("run_busy",     64'(busy),     64'd0);

        // First fetch in RUN
        fetch1(BASE + 64'h8, 32'h33, 1'b0, 2'b00);
        fetch_req = 1'b0;
        tick();
        check("valid_drops_when_idle_req", 64'(fetch_valid), 64'd0);

        // Stall: response to 0x4 held three cycles, then 0xC one cycle after release
        fetch1(BASE + 64'h4, 32'h22, 1'b0, 2'b00);
        fetch_stall = 1'b1;
        fetch_pc    = BASE + 64'hC;
        for (int i = 0; i < 3; i++) begin
            push(32'h22, 1'b0, 2'b00);
            tick();
        end
        fetch_stall = 1'b0;
        push(32'h44, 1'b0, 2'b00);
        tick();

        // Boundaries and fault priority, back to back
        for (int i = 0; i < 7; i++) begin
            fetch1(bvec[i].pc, bvec[i].inst, bvec[i].fault, bvec[i].cause);
        end

        // halt and run_start together in RUN, with a fetch also requested
        fetch_pc  = BASE;
        halt      = 1'b1;
        run_start = 1'b1;
        tick();
        halt      = 1'b0;
        run_start = 1'b0;
        check("halt_ld_ready", 64'(ld_ready),    64'd1);
        check("halt_busy",     64'(busy),        64'd0);
        check("halt_valid",    64'(fetch_valid), 64'd0);
        tick();
        check("halt_fetch_ignored", 64'(fetch_valid), 64'd0);
        fetch_req = 1'b0;

        // Parity: word 5 corrupted in storage when parity is compiled in
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
`ifdef IMEM_PARITY_EN
        dut.u_ram.mem[5][7] = ~dut.u_ram.mem[5][7];
        fetch1(BASE + 64'h14, 32'h0000_0013, 1'b1, 2'b11);
`else
        fetch1(BASE + 64'h14, 32'h0000_0055, 1'b0, 2'b00);
`endif
        fetch1(BASE, 32'h11, 1'b0, 2'b00);
        fetch_req = 1'b0;

        // Reset while a response is valid: outputs clear immediately
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("rst_run_valid",    64'(fetch_valid), 64'd0);
        check("rst_run_inst",     64'(fetch_inst),  64'd0);
        check("rst_run_ld_ready", 64'(ld_ready),    64'd1);
        tick();
        rstn = 1'b1;

        // Reset mid-load after two of four beats
        beat(8'd0, 32'hA0, 1'b0);
        beat(8'd1, 32'hA1, 1'b0);
        ld_valid = 1'b1;
        ld_addr  = 8'd2;
        ld_data  = 32'hA2;
        #2;
        rstn     = 1'b0;
        ld_valid = 1'b0;
        #1;
        check("midload_busy",  64'(busy),        64'd0);
        check("midload_valid", 64'(fetch_valid), 64'd0);
        tick();
        rstn = 1'b1;
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("midload_run_ld_ready", 64'(ld_ready), 64'd0);
        fetch1(BASE,           32'hA0, 1'b0, 2'b00);
        fetch1(BASE + 64'h4,   32'hA1, 1'b0, 2'b00);
        fetch1(BASE + 64'h8,   32'h33, 1'b0, 2'b00);
        fetch_req = 1'b0;
        tick();
        tick();

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
